irq_request_gen: RTL and testbench

- Interrupt source side of the core's interrupt handshake. It collects up to NSRC peripheral interrupt lines, latches them as pending, masks them and picks one by fixed priority.
- It drives int_sig into the interrupt controller and tracks ISR entry (sel_ISR) and return (ret_ISR, ISR_running) so that exactly one request is issued per ISR.
- It exposes a small register port that the ISR uses to read the claimed source id and to configure enable and trigger mode.

---
 rtl/irq_request_gen.sv | 153 +++++++++++++++
 tb/tb_irq_request_gen.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_request_gen.sv
// Interrupt request generator: synchronizes, latches and arbitrates
// peripheral lines and issues one request per ISR to the controller.
module irq_request_gen #(
  parameter int NSRC        = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic [NSRC-1:0] src_irq,
  input  logic            sel_ISR,
  input  logic            ISR_running,
  input  logic            ret_ISR,
  output logic            int_sig,
  input  logic            cfg_we,
  input  logic [1:0]      cfg_addr,
  input  logic [7:0]      cfg_wdata,
  output logic [7:0]      cfg_rdata,
  output logic [2:0]      irq_id
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_SERVICE, S_RETURN, S_GAP
  } state_t;

  state_t state_q, state_d;

  logic [NSRC-1:0] sync_q [SYNC_STAGES];
  logic [NSRC-1:0] prev_q;
  logic [NSRC-1:0] pend_q, pend_d;
  logic [NSRC-1:0] en_q, en_d;
  logic [NSRC-1:0] mode_q, mode_d;
  logic [2:0]      id_q, id_d;

  logic [NSRC-1:0] synced, rise, set_v;
  logic [NSRC-1:0] w1c, claim_m, elig;
  logic [2:0]      winner;
  logic            claim;
  logic            valid;
  logic [7:0]      rd_v;
  logic            unused_wdata;

  assign unused_wdata = ^cfg_wdata;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= src_irq;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
      prev_q <= synced;
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];
  assign rise   = synced & ~prev_q;
  assign set_v  = (mode_q & rise) | (~mode_q & synced);
  assign elig   = pend_q & en_q;

  // Lowest index wins: scan downward so the last hit is the lowest.
  always_comb begin
    winner = '0;
    for (int i = NSRC - 1; i >= 0; i--)
      if (elig[i]) winner = 3'(i);
  end

  always_comb begin
    en_d   = en_q;
    mode_d = mode_q;
    w1c    = '0;
    if (cfg_we) begin
      unique case (cfg_addr)
        2'd0:    en_d   = cfg_wdata[NSRC-1:0];
        2'd1:    w1c    = cfg_wdata[NSRC-1:0];
        2'd3:    mode_d = cfg_wdata[NSRC-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    claim   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (elig != '0 && !ISR_running && !ret_ISR) begin
          id_d    = winner;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (sel_ISR) begin
          claim   = 1'b1;
          state_d = S_SERVICE;
        end else if (elig == '0) begin
          state_d = S_IDLE;
        end
      end
      S_SERVICE: begin
        if (ret_ISR) state_d = S_RETURN;
      end
      S_RETURN: begin
        if (!ISR_running && !ret_ISR) state_d = S_GAP;
      end
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NSRC; i++)
      claim_m[i] = claim && (id_q == 3'(i));
  end

  // A new set in the same cycle as a clear keeps the bit pending.
  assign pend_d = (pend_q & ~(w1c | claim_m)) | set_v;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      id_q    <= '0;
      pend_q  <= '0;
      en_q    <= '0;
      mode_q  <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      pend_q  <= pend_d;
      en_q    <= en_d;
      mode_q  <= mode_d;
    end
  end

  assign valid = (state_q == S_REQ) || (state_q == S_SERVICE);

  always_comb begin
    rd_v = '0;
    unique case (cfg_addr)
      2'd0:    rd_v[NSRC-1:0] = en_q;
      2'd1:    rd_v[NSRC-1:0] = pend_q;
      2'd2:    rd_v = {valid, 4'b0000, id_q};
      default: rd_v[NSRC-1:0] = mode_q;
    endcase
  end

  assign cfg_rdata = rd_v;
  assign int_sig   = (state_q == S_REQ);
  assign irq_id    = id_q;

endmodule

// File: tb/tb_irq_request_gen.sv
// Bench for irq_request_gen: register table, directed handshake
// sequences and a randomized run against a reference model.
module tb_irq_request_gen;

  localparam int NS = 4;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          nrst;
  logic [NS-1:0] src_irq;
  logic          sel_ISR, ISR_running, ret_ISR;
  logic          int_sig;
  logic          cfg_we;
  logic [1:0]    cfg_addr;
  logic [7:0]    cfg_wdata;
  logic [7:0]    cfg_rdata;
  logic [2:0]    irq_id;

  irq_request_gen #(.NSRC(NS), .SYNC_STAGES(SS)) dut (
    .clk(clk), .nrst(nrst), .src_irq(src_irq),
    .sel_ISR(sel_ISR), .ISR_running(ISR_running),
    .ret_ISR(ret_ISR), .int_sig(int_sig),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
    .irq_id(irq_id)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       we;
    logic [1:0] a;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[8];

  typedef enum {M_IDLE, M_REQ, M_SERV, M_RET, M_GAP} mph_t;
  mph_t       m_ph;
  logic [3:0] m_pend, m_en, m_mode;
  logic [2:0] m_id;
  logic [3:0] hist[$];
  int         cst, cnt;

  task automatic chk(input string nm, input logic [7:0] got,
                     input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic rd(input string nm, input logic [1:0] a,
                    input logic [7:0] exp);
    cfg_addr = a;
    #1;
    chk(nm, cfg_rdata, exp);
  endtask

  task automatic ci(input string nm, input logic exp);
    chk(nm, {7'b0, int_sig}, {7'b0, exp});
  endtask

  task automatic nx();
    @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic do_reset();
    nrst = 1'b0; src_irq = '0; sel_ISR = 0; ISR_running = 0;
    ret_ISR = 0; cfg_we = 0; cfg_addr = '0; cfg_wdata = '0;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_req(input string nm, input int maxc);
    int n;
    n = 0;
    while (int_sig !== 1'b1 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (int_sig !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout int_sig=%b exp=1", nm, int_sig);
    end
  endtask

  task automatic claim();
    sel_ISR = 1'b1;
    @(negedge clk);
    sel_ISR = 1'b0;
    ISR_running = 1'b1;
  endtask

  task automatic ret_seq();
    ret_ISR = 1'b1;
    @(negedge clk);
    ret_ISR = 1'b0;
    ISR_running = 1'b0;
  endtask

  function automatic logic [7:0] m_read(input logic [1:0] a);
    logic v;
    v = (m_ph == M_REQ) || (m_ph == M_SERV);
    case (a)
      2'd0:    return {4'b0, m_en};
      2'd1:    return {4'b0, m_pend};
      2'd2:    return {v, 4'b0, 1'b0, m_id[1:0]};
      default: return {4'b0, m_mode};
    endcase
  endfunction

  task automatic model_reset();
    m_pend = '0; m_en = '0; m_mode = '0; m_id = '0;
    m_ph = M_IDLE;
    hist.delete();
    repeat (SS + 1) hist.push_back(4'b0);
  endtask

  // One clock of the rules: lines seen SS cycles late, edge/level
  // set beats any clear, one request per ISR, one idle cycle after return.
  task automatic model_step();
    logic [3:0] cur, prv, setb, clrb, el;
    int w;
    hist.push_back(src_irq);
    cur = hist[hist.size() - 1 - SS];
    prv = hist[hist.size() - 2 - SS];
    void'(hist.pop_front());
    el = m_pend & m_en;
    for (int i = 0; i < 4; i++)
      setb[i] = m_mode[i] ? (cur[i] && !prv[i]) : cur[i];
    clrb = (cfg_we && cfg_addr == 2'd1) ? cfg_wdata[3:0] : 4'b0;
    case (m_ph)
      M_IDLE:
        if (el != 0 && !ISR_running && !ret_ISR) begin
          w = 0;
          while (!el[w]) w++;
          m_id = 3'(w);
          m_ph = M_REQ;
        end
      M_REQ:
        if (sel_ISR) begin
          clrb = clrb | (4'b1 << m_id);
          m_ph = M_SERV;
        end else if (el == 0) begin
          m_ph = M_IDLE;
        end
      M_SERV: if (ret_ISR) m_ph = M_RET;
      M_RET:  if (!ISR_running && !ret_ISR) m_ph = M_GAP;
      default: m_ph = M_IDLE;
    endcase
    m_pend = (m_pend & ~clrb) | setb;
    if (cfg_we && cfg_addr == 2'd0) m_en = cfg_wdata[3:0];
    if (cfg_we && cfg_addr == 2'd3) m_mode = cfg_wdata[3:0];
  endtask

  initial begin
    tbl[0] = '{1'b0, 2'd0, 8'h00, 8'h00};
    tbl[1] = '{1'b1, 2'd0, 8'hA5, 8'h05};
    tbl[2] = '{1'b0, 2'd3, 8'h00, 8'h00};
    tbl[3] = '{1'b1, 2'd3, 8'hFC, 8'h0C};
    tbl[4] = '{1'b0, 2'd0, 8'h00, 8'h05};
    tbl[5] = '{1'b0, 2'd1, 8'h00, 8'h00};
    tbl[6] = '{1'b1, 2'd2, 8'hFF, 8'h00};
    tbl[7] = '{1'b1, 2'd1, 8'hFF, 8'h00};

    do_reset();
    ci("reset int_sig", 1'b0);
    chk("reset irq_id", {5'b0, irq_id}, 8'h00);
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].we) wr(tbl[i].a, tbl[i].d);
      rd($sformatf("tbl%0d", i), tbl[i].a, tbl[i].exp);
      ci($sformatf("tbl%0d int", i), 1'b0);
    end

    // Single edge on src 2: request latency and claim.
    do_reset();
    wr(2'd0, 8'h0F);
    wr(2'd3, 8'h0F);
    src_irq = 4'b0100;
    nx();
    src_irq = '0;
    for (int k = 0; k <= SS; k++) begin
      if (k == SS) rd("t1 pend set", 2'd1, 8'h04);
      if (k == SS - 1) rd("t1 pend early", 2'd1, 8'h00);
      ci($sformatf("t1 int low %0d", k), 1'b0);
      nx();
    end
    ci("t1 int high", 1'b1);
    chk("t1 id", {5'b0, irq_id}, 8'h02);
    claim();
    ci("t1 int drop", 1'b0);
    rd("t1 pend clr", 2'd1, 8'h00);
    rd("t1 addr2", 2'd2, 8'h82);
    ret_seq();
    repeat (4) begin
      nx();
      ci("t1 quiet", 1'b0);
    end
    rd("t1 addr2 idle", 2'd2, 8'h02);

    // Simultaneous edges on 1 and 3.
    do_reset();
    wr(2'd0, 8'h0F);
    wr(2'd3, 8'h0F);
    src_irq = 4'b1010;
    nx();
    src_irq = '0;
    wait_req("t2 req1", 10);
    chk("t2 id1", {5'b0, irq_id}, 8'h01);
    claim();
    rd("t2 pend", 2'd1, 8'h08);
    nx();
    ret_seq();
    ci("t2 ret", 1'b0);
    nx(); ci("t2 gap", 1'b0);
    nx(); ci("t2 idle", 1'b0);
    nx(); ci("t2 req2", 1'b1);
    chk("t2 id2", {5'b0, irq_id}, 8'h03);
    claim();
    ret_seq();

    // Level mode on src 0.
    do_reset();
    wr(2'd0, 8'h01);
    src_irq = 4'b0001;
    wait_req("t3 req1", 10);
    chk("t3 id", {5'b0, irq_id}, 8'h00);
    claim();
    nx();
    rd("t3 pend reset", 2'd1, 8'h01);
    ret_seq();
    nx(); nx(); ci("t3 gap", 1'b0);
    nx(); ci("t3 req2", 1'b1);
    src_irq = '0;
    repeat (SS + 2) nx();
    ci("t3 hold", 1'b1);
    claim();
    rd("t3 pend gone", 2'd1, 8'h00);
    ret_seq();
    repeat (5) begin
      nx();
      ci("t3 no req3", 1'b0);
    end

    // Masked source, late enable, W1C withdraws request.
    do_reset();
    wr(2'd3, 8'h0F);
    src_irq = 4'b0010;
    nx();
    src_irq = '0;
    repeat (SS + 1) nx();
    rd("t4 pend", 2'd1, 8'h02);
    ci("t4 masked", 1'b0);
    wr(2'd0, 8'h02);
    ci("t4 pre", 1'b0);
    nx();
    ci("t4 rise", 1'b1);
    wr(2'd1, 8'h02);
    ci("t4 still", 1'b1);
    nx();
    ci("t4 withdrawn", 1'b0);
    rd("t4 pend w1c", 2'd1, 8'h00);
    rd("t4 addr2", 2'd2, 8'h01);
    repeat (3) begin
      nx();
      ci("t4 quiet", 1'b0);
    end

    // Edge arriving during service is held until after the gap.
    do_reset();
    wr(2'd0, 8'h0F);
    wr(2'd3, 8'h0F);
    src_irq = 4'b0001;
    nx();
    src_irq = '0;
    wait_req("t5 req1", 10);
    chk("t5 id1", {5'b0, irq_id}, 8'h00);
    claim();
    src_irq = 4'b0100;
    nx();
    src_irq = '0;
    repeat (SS + 3) begin
      nx();
      ci("t5 no nest", 1'b0);
    end
    rd("t5 pend", 2'd1, 8'h04);
    ret_seq();
    ci("t5 ret", 1'b0);
    nx(); ci("t5 gap", 1'b0);
    nx(); ci("t5 idle", 1'b0);
    nx(); ci("t5 req2", 1'b1);
    chk("t5 id2", {5'b0, irq_id}, 8'h02);

    // Asynchronous reset while requesting.
    do_reset();
    wr(2'd0, 8'h0F);
    wr(2'd3, 8'h0F);
    src_irq = 4'b0010;
    nx();
    src_irq = '0;
    wait_req("t6 req", 10);
    #1 nrst = 1'b0;
    #1;
    ci("t6 int", 1'b0);
    chk("t6 id", {5'b0, irq_id}, 8'h00);
    for (int a = 0; a < 4; a++)
      rd($sformatf("t6 reg%0d", a), 2'(a), 8'h00);
    @(negedge clk);
    nrst = 1'b1;
    nx();
    ci("t6 after", 1'b0);
    rd("t6 pend lost", 2'd1, 8'h00);

    // Randomized run against the model.
    do_reset();
    model_reset();
    cst = 0;
    cnt = 0;
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] el;
      el = m_pend & m_en;
      if ($urandom_range(0, 9) == 0) src_irq = 4'($urandom);
      sel_ISR = 1'b0;
      ret_ISR = 1'b0;
      case (cst)
        0: begin
          ISR_running = 1'b0;
          if (m_ph == M_REQ && el != 0 &&
              $urandom_range(0, 2) == 0) begin
            sel_ISR = 1'b1;
            cst = 1;
            cnt = $urandom_range(1, 6);
          end
        end
        1: begin
          ISR_running = 1'b1;
          if (cnt == 0) begin
            ret_ISR = 1'b1;
            cst = 2;
          end else begin
            cnt--;
          end
        end
        default: begin
          if ($urandom_range(0, 1) == 0) begin
            ISR_running = 1'b1;
            ret_ISR = 1'b1;
          end else begin
            ISR_running = 1'b0;
            cst = 0;
          end
        end
      endcase
      cfg_we    = ($urandom_range(0, 9) == 0);
      cfg_addr  = 2'($urandom);
      cfg_wdata = 8'($urandom);
      #1;
      chk("rnd int_sig", {7'b0, int_sig}, {7'b0, m_ph == M_REQ});
      chk("rnd irq_id", {5'b0, irq_id}, {5'b0, m_id});
      chk("rnd rdata", cfg_rdata, m_read(cfg_addr));
      model_step();
      @(negedge clk);
    end
    cfg_we = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
